mxu_result_drain: RTL and testbench

MXU_RESULT_DRAIN -- requirements
Module: mxu_result_drain

---
 rtl/mxu_result_drain_if.sv | 25 ++
 rtl/mxu_result_drain.sv | 179 +++++++++++++++++
 tb/tb_mxu_result_drain.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mxu_result_drain_if.sv
// Column-result and aligned-row bus between the MXU bottom row, the drain and its consumer.
// Pure wiring, no latency.
// out_valid/out_ready handshake on the output; the column side has no backpressure.
interface mxu_result_drain_if #(
  parameter int bit_width = 64,
  parameter int N_COLS    = 4
);
  logic [N_COLS-1:0]           col_valid;
  logic [N_COLS*bit_width-1:0] col_data;
  logic                        out_valid;
  logic                        out_ready;
  logic [N_COLS*bit_width-1:0] out_data;

  // Environment side: drives column results and accepts aligned rows.
  modport master (
    output col_valid, col_data, out_ready,
    input  out_valid, out_data
  );

  // Drain side.
  modport slave (
    input  col_valid, col_data, out_ready,
    output out_valid, out_data
  );
endinterface

// File: rtl/mxu_result_drain.sv
// Deskews per-column MXU results into aligned rows, buffers them in a small FIFO and tracks job progress.
// Column j is delayed SKEW*(N_COLS-1-j) enabled cycles; a pushed row is visible on out_valid one cycle later.
// out_ready=0 holds the FIFO head stable; rows arriving while full (and with no pop) are dropped and flagged.
module mxu_result_drain #(
  parameter int bit_width = 64,
  parameter int N_COLS    = 4,
  parameter int SKEW      = 2,
  parameter int DEPTH     = 4
) (
  input  logic                clk,
  input  logic                sclr,
  input  logic                ce,
  mxu_result_drain_if.slave   bus,
  input  logic [15:0]         rows_expected,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic                skew_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = N_COLS * bit_width;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

  // Aligned view of all columns at the output of the deskew delay lines.
  logic [N_COLS-1:0] al_vld;
  logic [RW-1:0]     al_dat;

  for (genvar j = 0; j < N_COLS; j++) begin : g_col
    localparam int D = SKEW * (N_COLS - 1 - j);
    if (D == 0) begin : g_pass
      assign al_vld[j]                          = bus.col_valid[j];
      assign al_dat[j*bit_width +: bit_width]   = bus.col_data[j*bit_width +: bit_width];
    end else begin : g_dly
      logic [D-1:0]                vld_q, vld_d;
      logic [D-1:0][bit_width-1:0] dat_q, dat_d;

      // Shift the column one stage per enabled cycle; hold otherwise.
      always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (ce) begin
          for (int s = D - 1; s > 0; s--) begin
            vld_d[s] = vld_q[s-1];
            dat_d[s] = dat_q[s-1];
          end
          vld_d[0] = bus.col_valid[j];
          dat_d[0] = bus.col_data[j*bit_width +: bit_width];
        end
      end

      // Delay-line registers.
      always_ff @(posedge clk) begin
        if (sclr) begin
          vld_q <= '0;
          dat_q <= '0;
        end else begin
          vld_q <= vld_d;
          dat_q <= dat_d;
        end
      end

      assign al_vld[j]                        = vld_q[D-1];
      assign al_dat[j*bit_width +: bit_width] = dat_q[D-1];
    end
  end

  logic push_req, skew_hit, full, out_vld, pop, push_acc;

  logic [AW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]              count_q, count_d;
  logic [DEPTH-1:0][RW-1:0] mem_q, mem_d;
  logic                     overflow_q, overflow_d, skew_err_q, skew_err_d;

  state_t      state_q, state_d;
  logic [15:0] row_cnt_q, row_cnt_d, rows_exp_q, rows_exp_d;
  logic        done_q, done_d;

  assign push_req = ce & (&al_vld);
  assign skew_hit = ce & (|al_vld) & ~(&al_vld);
  assign full     = (count_q == FULL_CNT);
  assign out_vld  = (count_q != '0);
  assign pop      = out_vld & bus.out_ready;
  // A pop frees the slot in the same cycle, so a full FIFO can still take a row.
  assign push_acc = push_req & (~full | pop);

  // FIFO pointers, occupancy, storage and sticky error flags.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    mem_d      = mem_q;
    overflow_d = overflow_q | (push_req & full & ~pop);
    skew_err_d = skew_err_q | skew_hit;
    if (push_acc) begin
      mem_d[wr_ptr_q] = al_dat;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_acc, pop})
      2'b10:   count_d = count_q + ONE_CNT;
      2'b01:   count_d = count_q - ONE_CNT;
      default: count_d = count_q;
    endcase
  end

  // Job FSM: row counting in RUN, drain wait in FLUSH; exit uses post-update occupancy.
  always_comb begin
    state_d    = state_q;
    row_cnt_d  = row_cnt_q;
    rows_exp_d = rows_exp_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          row_cnt_d  = '0;
          rows_exp_d = rows_expected;
          state_d    = (rows_expected == 16'd0) ? S_FLUSH : S_RUN;
        end
      end
      S_RUN: begin
        if (push_req) begin
          row_cnt_d = row_cnt_q + 16'd1;
          if (row_cnt_d == rows_exp_q) begin
            state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        if (count_d == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers for FIFO, flags and FSM.
  always_ff @(posedge clk) begin
    if (sclr) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      mem_q      <= '0;
      overflow_q <= 1'b0;
      skew_err_q <= 1'b0;
      state_q    <= S_IDLE;
      row_cnt_q  <= '0;
      rows_exp_q <= '0;
      done_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      mem_q      <= mem_d;
      overflow_q <= overflow_d;
      skew_err_q <= skew_err_d;
      state_q    <= state_d;
      row_cnt_q  <= row_cnt_d;
      rows_exp_q <= rows_exp_d;
      done_q     <= done_d;
    end
  end

  assign bus.out_valid = out_vld;
  assign bus.out_data  = out_vld ? mem_q[rd_ptr_q] : '0;
  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign overflow      = overflow_q;
  assign skew_err      = skew_err_q;

endmodule

// File: tb/tb_mxu_result_drain.sv
// Randomized and directed bench for mxu_result_drain against a queue-based reference model.
// Outputs are compared every cycle at the falling edge; the model advances per rising edge.
// out_ready is driven randomly or held low to exercise backpressure and overflow.
module tb_mxu_result_drain;
  localparam int BW = 16;
  localparam int NC = 4;
  localparam int SK = 2;
  localparam int DP = 4;
  localparam int NS = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        sclr, ce, start;
  logic [15:0] rows_expected;
  logic        busy, done, overflow, skew_err;

  mxu_result_drain_if #(.bit_width(BW), .N_COLS(NC)) bus();

  mxu_result_drain #(.bit_width(BW), .N_COLS(NC), .SKEW(SK), .DEPTH(DP)) dut (
    .clk           (clk),
    .sclr          (sclr),
    .ce            (ce),
    .bus           (bus),
    .rows_expected (rows_expected),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .overflow      (overflow),
    .skew_err      (skew_err)
  );

  int checks = 0;
  int failures = 0;

  // Stimulus plan, indexed by enabled-cycle number since the last reset.
  bit          pv [NC][NS];
  logic [BW-1:0] pd [NC][NS];
  int          k_drv = 0;

  // Reference model state.
  bit            mhv [NC][NS];
  logic [BW-1:0] mhd [NC][NS];
  int            m_ce = 0;
  logic [NC*BW-1:0] mq[$];
  int            m_state = 0;   // 0 idle, 1 run, 2 flush
  int            m_rows = 0;
  int            m_exp = 0;
  bit            m_done = 0, m_ovf = 0, m_skerr = 0;

  function automatic int dly(int j);
    return SK * (NC - 1 - j);
  endfunction

  function automatic logic [NC*BW-1:0] mkrow(logic [BW-1:0] base);
    logic [NC*BW-1:0] r;
    for (int j = 0; j < NC; j++) r[j*BW +: BW] = base + BW'(j);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one rising edge using the currently driven inputs.
  task automatic model_edge();
    bit pop, push, all1, any1, full, v;
    int idx;
    logic [NC*BW-1:0] row;
    if (sclr) begin
      mq.delete();
      m_state = 0; m_rows = 0; m_exp = 0;
      m_done = 0; m_ovf = 0; m_skerr = 0; m_ce = 0;
      return;
    end
    pop  = (mq.size() > 0) && bus.out_ready;
    push = 0; all1 = 1; any1 = 0; row = '0;
    if (ce) begin
      for (int j = 0; j < NC; j++) begin
        mhv[j][m_ce] = bus.col_valid[j];
        mhd[j][m_ce] = bus.col_data[j*BW +: BW];
      end
      for (int j = 0; j < NC; j++) begin
        idx = m_ce - dly(j);
        v = (idx >= 0) ? mhv[j][idx] : 1'b0;
        all1 &= v;
        any1 |= v;
        row[j*BW +: BW] = (idx >= 0) ? mhd[j][idx] : '0;
      end
      m_ce++;
      push = all1;
      if (any1 && !all1) m_skerr = 1;
    end
    full = (mq.size() == DP);
    if (pop) void'(mq.pop_front());
    if (push) begin
      if (!full || pop) mq.push_back(row);
      else m_ovf = 1;
    end
    m_done = 0;
    case (m_state)
      0: if (start) begin
           m_rows = 0;
           m_exp = int'(rows_expected);
           m_state = (rows_expected == 0) ? 2 : 1;
         end
      1: if (push) begin
           m_rows++;
           if (m_rows == m_exp) m_state = 2;
         end
      default: if (mq.size() == 0) begin
           m_state = 0;
           m_done = 1;
         end
    endcase
  endtask

  // Compare all outputs against the model, then let one rising edge happen.
  task automatic step();
    @(negedge clk);
    chk("out_valid", 64'(bus.out_valid), 64'(mq.size() > 0));
    chk("out_data",  64'(bus.out_data),  (mq.size() > 0) ? 64'(mq[0]) : 64'd0);
    chk("busy",      64'(busy),          64'(m_state != 0));
    chk("done",      64'(done),          64'(m_done));
    chk("overflow",  64'(overflow),      64'(m_ovf));
    chk("skew_err",  64'(skew_err),      64'(m_skerr));
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input bit ce_i, input bit rdy, input bit st, input logic [15:0] re);
    sclr = 0; ce = ce_i; bus.out_ready = rdy; start = st; rows_expected = re;
    if (ce_i) begin
      for (int j = 0; j < NC; j++) begin
        bus.col_valid[j]           = pv[j][k_drv];
        bus.col_data[j*BW +: BW]   = pd[j][k_drv];
      end
      if (k_drv < NS - 1) k_drv++;
    end else begin
      bus.col_valid = NC'($urandom);
      bus.col_data  = {$urandom, $urandom};
    end
    step();
  endtask

  task automatic plan_row(input int t_al, input logic [BW-1:0] base, input bit late2);
    int t;
    for (int j = 0; j < NC; j++) begin
      t = t_al - dly(j) + ((late2 && j == 2) ? 1 : 0);
      if (t >= 0 && t < NS) begin
        pv[j][t] = 1'b1;
        pd[j][t] = base + BW'(j);
      end
    end
  endtask

  task automatic do_reset();
    sclr = 1; ce = 1'($urandom); start = 1; rows_expected = 16'd3;
    bus.col_valid = '1; bus.col_data = {$urandom, $urandom}; bus.out_ready = 1;
    step();
    step();
    for (int j = 0; j < NC; j++)
      for (int t = 0; t < NS; t++) begin pv[j][t] = 0; pd[j][t] = '0; end
    k_drv = 0;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data",  64'(bus.out_data),  64'd0);
    chk("rst_busy",      64'(busy),          64'd0);
    chk("rst_done",      64'(done),          64'd0);
    chk("rst_overflow",  64'(overflow),      64'd0);
    chk("rst_skew_err",  64'(skew_err),      64'd0);
  endtask

  initial begin
    sclr = 1; ce = 0; start = 0; rows_expected = '0;
    bus.col_valid = '0; bus.col_data = '0; bus.out_ready = 0;
    @(posedge clk); #1;

    // Single-row job with data j+1 per column.
    do_reset();
    plan_row(6, 16'd1, 0);
    cyc(1, 1, 1, 16'd1);
    for (int c = 1; c <= 6; c++) cyc(1, 1, 0, 16'd0);
    chk("a_valid", 64'(bus.out_valid), 64'd1);
    chk("a_data",  64'(bus.out_data),  64'h0004_0003_0002_0001);
    chk("a_busy",  64'(busy),          64'd1);
    cyc(1, 1, 0, 16'd0);
    chk("a_done",  64'(done),          64'd1);
    chk("a_idle",  64'(busy),          64'd0);
    for (int c = 0; c < 3; c++) cyc(1, 1, 0, 16'd0);

    // Five rows into a four-deep FIFO with no reader.
    do_reset();
    for (int r = 0; r < 5; r++) plan_row(6 + r, BW'(16'h10 * (r + 1)), 0);
    cyc(1, 0, 1, 16'd5);
    for (int c = 1; c <= 10; c++) cyc(1, 0, 0, 16'd0);
    chk("b_overflow", 64'(overflow), 64'd1);
    for (int r = 0; r < 4; r++) begin
      chk("b_drain", 64'(bus.out_data), 64'(mkrow(BW'(16'h10 * (r + 1)))));
      cyc(1, 1, 0, 16'd0);
    end
    chk("b_empty", 64'(bus.out_valid), 64'd0);
    for (int c = 0; c < 3; c++) cyc(1, 1, 0, 16'd0);

    // Push into a full FIFO while popping.
    do_reset();
    for (int r = 0; r < 5; r++) plan_row(6 + r, BW'(16'h20 * (r + 1)), 0);
    cyc(1, 0, 1, 16'd5);
    for (int c = 1; c <= 9; c++) cyc(1, 0, 0, 16'd0);
    cyc(1, 1, 0, 16'd0);
    for (int c = 11; c <= 13; c++) cyc(1, 0, 0, 16'd0);
    chk("c_overflow", 64'(overflow), 64'd0);
    for (int r = 1; r < 5; r++) begin
      chk("c_drain", 64'(bus.out_data), 64'(mkrow(BW'(16'h20 * (r + 1)))));
      cyc(1, 1, 0, 16'd0);
    end
    chk("c_empty", 64'(bus.out_valid), 64'd0);

    // Column 2 one cycle late.
    do_reset();
    plan_row(6, 16'h50, 1);
    cyc(1, 1, 1, 16'd1);
    for (int c = 1; c < 10; c++) cyc(1, 1, 0, 16'd0);
    chk("d_skew_err", 64'(skew_err), 64'd1);
    chk("d_no_push",  64'(bus.out_valid), 64'd0);
    chk("d_busy",     64'(busy), 64'd1);

    // Three disabled cycles in the middle of the skew window.
    do_reset();
    plan_row(6, 16'h60, 0);
    for (int c = 0; c <= 9; c++) begin
      cyc(!(c >= 3 && c <= 5), 1, 0, 16'd0);
      if (c == 8) chk("e_not_yet", 64'(bus.out_valid), 64'd0);
    end
    chk("e_valid", 64'(bus.out_valid), 64'd1);
    chk("e_data",  64'(bus.out_data),  64'(mkrow(16'h60)));
    for (int c = 0; c < 3; c++) cyc(1, 1, 0, 16'd0);

    // Reset in RUN with two rows buffered.
    do_reset();
    plan_row(6, 16'h70, 0);
    plan_row(7, 16'h80, 0);
    cyc(1, 0, 1, 16'd5);
    for (int c = 1; c <= 8; c++) cyc(1, 0, 0, 16'd0);
    chk("f_valid", 64'(bus.out_valid), 64'd1);
    chk("f_busy",  64'(busy), 64'd1);
    sclr = 1;
    step();
    chk("f_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("f_rst_busy",  64'(busy), 64'd0);
    chk("f_rst_done",  64'(done), 64'd0);
    for (int c = 0; c < 4; c++) cyc(1, 1, 0, 16'd0);

    // Random traffic, enables, backpressure and job starts.
    do_reset();
    for (int t = 8; t < 580; t++)
      if ($urandom_range(0, 9) < 3) plan_row(t, BW'($urandom), $urandom_range(0, 29) == 0);
    for (int c = 0; c < 650; c++)
      cyc($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 6,
          $urandom_range(0, 19) == 0, 16'($urandom_range(0, 6)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
